// File: rtl/mouse_position_tracker_pkg.sv
// Shared types and constants for the PS/2 mouse tracker.
// Packet FSM encoding, byte0 bit positions, default screen size.
package mouse_pkg;

  typedef enum logic [1:0] {
    S_B0 = 2'd0,
    S_B1 = 2'd1,
    S_B2 = 2'd2
  } state_e;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XOV   = 6;
  localparam int YOV   = 7;

  localparam int H_DEF       = 640;
  localparam int V_DEF       = 480;
  localparam int TIMEOUT_DEF = 1_000_000;

endpackage

// File: rtl/mouse_position_tracker_if.sv
// Byte-receiver input and cursor outputs of the mouse tracker.
// master drives the PS/2 bytes; slave is the tracker itself.
interface mouse_position_tracker_if;

  logic [7:0] rx_data;
  logic       rx_done;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic       btn_l;
  logic       btn_r;
  logic       pkt_tick;

  modport master (
    output rx_data, rx_done,
    input  mouse_x, mouse_y,
    input  btn_l, btn_r, pkt_tick
  );

  modport slave (
    input  rx_data, rx_done,
    output mouse_x, mouse_y,
    output btn_l, btn_r, pkt_tick
  );

endinterface

// File: rtl/mouse_position_tracker_axis_accum.sv
// One cursor axis: adds a signed delta and saturates to 0..MAX_PLUS1-1.
// NEG flips the delta so the Y axis can run top-down.
module mouse_axis_accum #(
  parameter int MAX_PLUS1 = 640,
  parameter bit NEG       = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_i,
  input  logic              hold_i,
  input  logic signed [8:0] delta_i,
  output logic [9:0]        pos_o
);

  localparam logic [9:0] MAX    = 10'(MAX_PLUS1 - 1);
  localparam logic [9:0] CENTRE = 10'(MAX_PLUS1 / 2);

  logic [9:0]         pos_q, pos_d;
  logic signed [10:0] dext, step, sum;

  // Saturating add of the (optionally negated) delta
  always_comb begin
    dext  = {{2{delta_i[8]}}, delta_i};
    step  = NEG ? -dext : dext;
    sum   = $signed({1'b0, pos_q}) + step;
    pos_d = pos_q;
    if (upd_i && !hold_i) begin
      if (sum[10])
        pos_d = '0;
      else if (sum > $signed({1'b0, MAX}))
        pos_d = MAX;
      else
        pos_d = sum[9:0];
    end
  end

  // Position register, centred on reset
  always_ff @(posedge clk) begin
    if (reset) pos_q <= CENTRE;
    else       pos_q <= pos_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/mouse_position_tracker.sv
// Assembles 3-byte PS/2 mouse packets and tracks the cursor.
// Position and buttons change only in the pkt_tick cycle.
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int H_PIXELS       = H_DEF,
  parameter int V_PIXELS       = V_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input logic                     clk,
  input logic                     reset,
  mouse_position_tracker_if.slave bus
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  state_e          st_q, st_d, cur;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      b0_q, b0_d;
  logic [7:0]      b1_q, b1_d;
  logic [7:0]      b2_q, b2_d;
  logic            upd_q, upd_d;
  logic            btn_l_q, btn_r_q, tick_q;
  logic            timeout;
  logic [9:0]      x_pos, y_pos;

  // Packet FSM: timeout folds back to S_B0 before the byte is decoded
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    upd_d   = 1'b0;
    timeout = (st_q != S_B0) && (cnt_q == TMAX);
    cur     = timeout ? S_B0 : st_q;
    st_d    = cur;
    cnt_d   = (cur != S_B0) ? cnt_q + 1'b1 : '0;
    if (bus.rx_done) begin
      unique case (1'b1)
        cur == S_B0: begin
          if (bus.rx_data[SYNC]) begin
            b0_d  = bus.rx_data;
            st_d  = S_B1;
            cnt_d = '0;
          end
        end
        cur == S_B1: begin
          b1_d  = bus.rx_data;
          st_d  = S_B2;
          cnt_d = '0;
        end
        cur == S_B2: begin
          b2_d  = bus.rx_data;
          st_d  = S_B0;
          cnt_d = '0;
          upd_d = 1'b1;
        end
        default: st_d = S_B0;
      endcase
    end
  end

  // FSM, byte latches and timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= S_B0;
      cnt_q <= '0;
      b0_q  <= '0;
      b1_q  <= '0;
      b2_q  <= '0;
      upd_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      b0_q  <= b0_d;
      b1_q  <= b1_d;
      b2_q  <= b2_d;
      upd_q <= upd_d;
    end
  end

  // Buttons and tick follow the pending update by one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_l_q <= 1'b0;
      btn_r_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= upd_q;
      if (upd_q) begin
        btn_l_q <= b0_q[BTN_L];
        btn_r_q <= b0_q[BTN_R];
      end
    end
  end

  mouse_axis_accum #(
    .MAX_PLUS1 (H_PIXELS),
    .NEG       (1'b0)
  ) u_x (
    .clk     (clk),
    .reset   (reset),
    .upd_i   (upd_q),
    .hold_i  (b0_q[XOV]),
    .delta_i ({b0_q[XS], b1_q}),
    .pos_o   (x_pos)
  );

  mouse_axis_accum #(
    .MAX_PLUS1 (V_PIXELS),
    .NEG       (1'b1)
  ) u_y (
    .clk     (clk),
    .reset   (reset),
    .upd_i   (upd_q),
    .hold_i  (b0_q[YOV]),
    .delta_i ({b0_q[YS], b2_q}),
    .pos_o   (y_pos)
  );

  assign bus.mouse_x  = x_pos;
  assign bus.mouse_y  = y_pos;
  assign bus.btn_l    = btn_l_q;
  assign bus.btn_r    = btn_r_q;
  assign bus.pkt_tick = tick_q;

endmodule
